fp_mul_lanes: RTL and testbench

Multi-lane, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control, parametrised in exponent width, mantissa width and lane count. It is the successor to the single-lane `fp_mul` in the MIMO-OFDM datapath. It feeds the complex-multiply and equaliser stages, where several antenna streams are multiplied per cycle. Beyond a plain multiplier, it adds special-value handling, rounding, exception flags and backpressure.

---
 rtl/fp_mul_lanes.sv | 169 ++++++++++++++++
 tb/tb_fp_mul_lanes.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_lanes.sv
// fp_mul_lanes: LANES-wide IEEE-754-style multiplier; denormals flush to zero; per-lane {invalid, overflow, underflow}.
// Latency 3 cycles, 1 beat/cycle. Define FP_MUL_LANES_RNE_EN for round-to-nearest-even, otherwise truncate.
// Backpressure: every stage holds while enable is low or out_valid && !out_ready; in_ready is that advance term.
module fp_mul_lanes #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*I_DATA-1:0] idataA,
    input  logic [LANES*I_DATA-1:0] idataB,
    output logic [LANES*I_DATA-1:0] odata,
    output logic [LANES*3-1:0]      oflags,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int EW   = I_EXP + 2;
    localparam int PW   = 2 * I_MNT + 2;
    localparam int BIAS = (1 << (I_EXP - 1)) - 1;
    localparam int EMAX = (1 << I_EXP) - 1;

    logic w_adv;
    logic r_s1_vld, r_s2_vld, r_s3_vld;

    assign w_adv     = enable && (!r_s3_vld || out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_s3_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [I_DATA-1:0] w_a, w_b;
        logic [I_EXP-1:0]  w_ea, w_eb;
        logic [I_MNT-1:0]  w_ma, w_mb;
        logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;
        logic [EW-1:0]     w_esum;
        logic [PW-1:0]     w_prod;

        assign w_a    = idataA[k*I_DATA +: I_DATA];
        assign w_b    = idataB[k*I_DATA +: I_DATA];
        assign w_ea   = w_a[I_MNT +: I_EXP];
        assign w_eb   = w_b[I_MNT +: I_EXP];
        assign w_ma   = w_a[I_MNT-1:0];
        assign w_mb   = w_b[I_MNT-1:0];
        assign w_za   = (w_ea == '0);
        assign w_zb   = (w_eb == '0);
        assign w_ia   = (w_ea == '1) && (w_ma == '0);
        assign w_ib   = (w_eb == '1) && (w_mb == '0);
        assign w_na   = (w_ea == '1) && (w_ma != '0);
        assign w_nb   = (w_eb == '1) && (w_mb != '0);
        assign w_esum = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);
        assign w_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});

        logic          r_s1_sgn, r_s1_nan, r_s1_inf, r_s1_zero;
        logic [EW-1:0] r_s1_exp;
        logic [PW-1:0] r_s1_prod;

        // Product of two [1,2) significands lies in [1,4): at most one right shift.
        logic             w_hi, w_inc, w_cy;
        logic [I_MNT:0]   w_mnt_n, w_drop;
        logic [I_MNT+1:0] w_mnt_r;
        logic [I_MNT-1:0] w_mnt_f;
        logic [EW-1:0]    w_exp_n;

        assign w_hi    = r_s1_prod[PW-1];
        assign w_mnt_n = w_hi ? r_s1_prod[PW-1 -: I_MNT+1] : r_s1_prod[PW-2 -: I_MNT+1];
        assign w_drop  = w_hi ? r_s1_prod[I_MNT:0] : {r_s1_prod[I_MNT-1:0], 1'b0};
`ifdef FP_MUL_LANES_RNE_EN
        logic w_g, w_s;
        assign w_g   = w_drop[I_MNT];
        assign w_s   = |w_drop[I_MNT-1:0];
        assign w_inc = w_g && (w_s || w_mnt_n[0]);
`else
        logic w_unused_drop;
        assign w_unused_drop = ^w_drop;
        assign w_inc         = 1'b0;
`endif
        assign w_mnt_r = {1'b0, w_mnt_n} + (I_MNT+2)'(w_inc);
        assign w_cy    = w_mnt_r[I_MNT+1];
        assign w_mnt_f = w_cy ? w_mnt_r[I_MNT:1] : w_mnt_r[I_MNT-1:0];
        assign w_exp_n = r_s1_exp + EW'(w_hi) + EW'(w_cy);

        logic             r_s2_sgn, r_s2_nan, r_s2_inf, r_s2_zero;
        logic [EW-1:0]    r_s2_exp;
        logic [I_MNT-1:0] r_s2_mnt;

        // Exponent is two's complement in EW bits; MSB set means negative.
        logic              w_ovf, w_unf;
        logic [I_DATA-1:0] w_res;
        logic [2:0]        w_flg;

        assign w_ovf = !r_s2_exp[EW-1] && (r_s2_exp >= EW'(EMAX));
        assign w_unf = r_s2_exp[EW-1] || (r_s2_exp == '0);

        always_comb begin
            w_res = {r_s2_sgn, r_s2_exp[I_EXP-1:0], r_s2_mnt};
            w_flg = 3'b000;
            if (r_s2_nan) begin
                w_res = {1'b0, {I_EXP{1'b1}}, 1'b1, {(I_MNT-1){1'b0}}};
                w_flg = 3'b100;
            end else if (r_s2_inf) begin
                w_res = {r_s2_sgn, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
            end else if (r_s2_zero) begin
                w_res = {r_s2_sgn, {(I_DATA-1){1'b0}}};
            end else if (w_ovf) begin
                w_res = {r_s2_sgn, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
                w_flg = 3'b010;
            end else if (w_unf) begin
                w_res = {r_s2_sgn, {(I_DATA-1){1'b0}}};
                w_flg = 3'b001;
            end
        end

        logic [I_DATA-1:0] r_s3_dat;
        logic [2:0]        r_s3_flg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1_sgn  <= 1'b0;
                r_s1_nan  <= 1'b0;
                r_s1_inf  <= 1'b0;
                r_s1_zero <= 1'b0;
                r_s1_exp  <= '0;
                r_s1_prod <= '0;
                r_s2_sgn  <= 1'b0;
                r_s2_nan  <= 1'b0;
                r_s2_inf  <= 1'b0;
                r_s2_zero <= 1'b0;
                r_s2_exp  <= '0;
                r_s2_mnt  <= '0;
                r_s3_dat  <= '0;
                r_s3_flg  <= 3'b000;
            end else if (w_adv) begin
                r_s1_sgn  <= w_a[I_DATA-1] ^ w_b[I_DATA-1];
                r_s1_nan  <= w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib);
                r_s1_inf  <= w_ia || w_ib;
                r_s1_zero <= w_za || w_zb;
                r_s1_exp  <= w_esum;
                r_s1_prod <= w_prod;
                r_s2_sgn  <= r_s1_sgn;
                r_s2_nan  <= r_s1_nan;
                r_s2_inf  <= r_s1_inf;
                r_s2_zero <= r_s1_zero;
                r_s2_exp  <= w_exp_n;
                r_s2_mnt  <= w_mnt_f;
                r_s3_dat  <= w_res;
                r_s3_flg  <= r_s2_vld ? w_flg : 3'b000;
            end
        end

        assign odata[k*I_DATA +: I_DATA] = r_s3_dat;
        assign oflags[k*3 +: 3]          = r_s3_flg;
    end
endmodule

// File: tb/tb_fp_mul_lanes.sv
// Bench for fp_mul_lanes (fp32, 4 lanes): directed vector table, random streams against an
// arithmetic reference model, stall/enable hold behaviour and mid-stream reset.
module tb_fp_mul_lanes;
    localparam int L  = 4;
    localparam int W  = 32;
    localparam int NV = 16;
`ifdef FP_MUL_LANES_RNE_EN
    localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

    logic           clk = 1'b0;
    logic           reset, enable, in_valid, in_ready, out_valid, out_ready;
    logic [L*W-1:0] idataA, idataB, odata;
    logic [L*3-1:0] oflags;

    always #5 clk = ~clk;

    fp_mul_lanes #(.I_EXP(8), .I_MNT(23), .I_DATA(W), .LANES(L)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .idataA(idataA), .idataB(idataB), .odata(odata), .oflags(oflags),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [L*W-1:0] d;
        logic [L*3-1:0] f;
    } beat_t;

    vec_t  tv[NV];
    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    n_out = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Exact significand product, then scale, round and range-check as real-number arithmetic.
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, drop;
        logic            s;
        bit              za, zb, ia, ib, na, nb;
        longint unsigned p, q;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC00000};
        if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
        if (za || zb) return {3'b000, s, 31'h0};
        p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e    = ea + eb - 127;
        drop = 23;
        if (p >= (64'd1 << 47)) begin
            drop = 24;
            e    = e + 1;
        end
        q = p >> drop;
`ifdef FP_MUL_LANES_RNE_EN
        begin
            longint unsigned rem, half;
            rem  = p - (q << drop);
            half = 64'd1 << (drop - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
`endif
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[30:23] = 8'($urandom_range(40, 215));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_rand();
        for (int k = 0; k < L; k++) begin
            idataA[k*W +: W] = rnd_fp();
            idataB[k*W +: W] = rnd_fp();
        end
    endtask

    task automatic push_exp();
        beat_t       e;
        logic [34:0] r;
        for (int k = 0; k < L; k++) begin
            r = ref_mul(idataA[k*W +: W], idataB[k*W +: W]);
            e.d[k*W +: W] = r[31:0];
            e.f[k*3 +: 3] = r[34:32];
        end
        exp_q.push_back(e);
    endtask

    task automatic pop_chk();
        beat_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got out_valid with data %h, want no beat", odata);
            return;
        end
        e = exp_q.pop_front();
        n_out++;
        for (int k = 0; k < L; k++) begin
            chk($sformatf("out_b%0d_l%0d_data", n_out, k), 128'(odata[k*W +: W]), 128'(e.d[k*W +: W]));
            chk($sformatf("out_b%0d_l%0d_flags", n_out, k), 128'(oflags[k*3 +: 3]), 128'(e.f[k*3 +: 3]));
        end
    endtask

    task automatic run_stream(input int nbeats, input int ro_lo, input int ro_hi,
                              input int en_lo, input int en_hi, input bit rnd_ready);
        int             sent, cyc, got0;
        bit             stall, acc;
        logic [L*W-1:0] snap_d;
        logic [L*3-1:0] snap_f;
        sent = 0;
        cyc  = 0;
        got0 = n_out;
        load_rand();
        while ((sent < nbeats || exp_q.size() != 0) && cyc < 400) begin
            in_valid  = (sent < nbeats);
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : !(cyc >= ro_lo && cyc < ro_hi);
            enable    = !(cyc >= en_lo && cyc < en_hi);
            #1;
            chk($sformatf("in_ready_c%0d", cyc), 128'(in_ready), 128'(enable && (!out_valid || out_ready)));
            stall  = out_valid && !(enable && out_ready);
            snap_d = odata;
            snap_f = oflags;
            acc    = in_valid && in_ready;
            if (out_valid && out_ready && enable) pop_chk();
            if (acc) begin
                push_exp();
                sent++;
            end
            tick();
            if (stall) begin
                chk($sformatf("hold_vld_c%0d", cyc), 128'(out_valid), 128'(1));
                chk($sformatf("hold_data_c%0d", cyc), 128'(odata), 128'(snap_d));
                chk($sformatf("hold_flags_c%0d", cyc), 128'(oflags), 128'(snap_f));
            end
            if (acc) load_rand();
            cyc++;
        end
        chk("stream_count", 128'(n_out - got0), 128'(nbeats));
        chk("stream_drained", 128'(exp_q.size()), 128'(0));
        in_valid  = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] r;
        logic [31:0] ra, rb;
        tv[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
        tv[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
        tv[2]  = '{32'h3F800001, 32'h3FC00000, TIE_RES,      3'b000};
        tv[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
        tv[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        tv[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
        tv[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
        tv[7]  = '{32'h7FC00123, 32'h3F800000, 32'h7FC00000, 3'b100};
        tv[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000};
        tv[9]  = '{32'h00400000, 32'h7F000000, 32'h00000000, 3'b000};
        tv[10] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000};
        tv[11] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010};
        tv[12] = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001};
        tv[13] = '{32'hC0000000, 32'hC0400000, 32'h40C00000, 3'b000};
        tv[14] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100};
        tv[15] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 3'b000};

        reset     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idataA    = '0;
        idataB    = '0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_odata", 128'(odata), 128'(0));
        chk("rst_oflags", 128'(oflags), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        #1 chk("in_ready_en0", 128'(in_ready), 128'(0));
        enable = 1'b1;
        #1 chk("in_ready_en1", 128'(in_ready), 128'(1));
        out_ready = 1'b1;

        for (int j = 0; j < NV / L; j++) begin
            for (int k = 0; k < L; k++) begin
                idataA[k*W +: W] = tv[j*L+k].a;
                idataB[k*W +: W] = tv[j*L+k].b;
            end
            in_valid = 1'b1;
            #1 chk($sformatf("dir%0d_in_ready", j), 128'(in_ready), 128'(1));
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("dir%0d_lat2_valid", j), 128'(out_valid), 128'(0));
            tick();
            chk($sformatf("dir%0d_lat3_valid", j), 128'(out_valid), 128'(1));
            for (int k = 0; k < L; k++) begin
                chk($sformatf("vec%0d_data", j*L+k), 128'(odata[k*W +: W]), 128'(tv[j*L+k].r));
                chk($sformatf("vec%0d_flags", j*L+k), 128'(oflags[k*3 +: 3]), 128'(tv[j*L+k].f));
            end
            tick();
        end

        run_stream(20, 8, 13, -1, -1, 1'b0);
        run_stream(12, -1, -1, 3, 7, 1'b0);
        run_stream(60, -1, -1, -1, -1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            load_rand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1 chk("rst_mid_pre_valid", 128'(out_valid), 128'(1));
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_odata", 128'(odata), 128'(0));
        chk("rst_mid_oflags", 128'(oflags), 128'(0));
        tick();
        tick();
        reset = 1'b1;
        #1 chk("rst_rel_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst_no_stale_%0d", i), 128'(out_valid), 128'(0));
        end
        ra = rnd_fp();
        rb = rnd_fp();
        for (int k = 0; k < L; k++) begin
            idataA[k*W +: W] = (k == 0) ? ra : rnd_fp();
            idataB[k*W +: W] = (k == 0) ? rb : rnd_fp();
        end
        r = ref_mul(ra, rb);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_new_lat2_valid", 128'(out_valid), 128'(0));
        tick();
        chk("rst_new_lat3_valid", 128'(out_valid), 128'(1));
        chk("rst_new_data", 128'(odata[W-1:0]), 128'(r[31:0]));
        chk("rst_new_flags", 128'(oflags[2:0]), 128'(r[34:32]));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
